// File: rtl/rggen_adapter_pipelined_if.sv
// Handshake interfaces between the bus bridge, the adapter and the register array.
// status encoding: 2'b00 OKAY, 2'b01 EXOKAY, 2'b10 SLAVE_ERROR, 2'b11 DECODE_ERROR.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  logic [1:0]               access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (output valid, access, address, write_data, strobe,
                  input  ready, status, read_data);
  modport slave  (input  valid, access, address, write_data, strobe,
                  output ready, status, read_data);
endinterface

interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  logic [1:0]               access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     active;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport host     (output valid, access, address, write_data, strobe,
                    input  active, ready, status, read_data);
  modport register (input  valid, access, address, write_data, strobe,
                    output active, ready, status, read_data);
endinterface

// File: rtl/rggen_adapter_pipelined.sv
// Bus-to-register adapter with optional request slice, registered response,
// address range pre-decode and response timeout.
module rggen_adapter_pipelined #(
  parameter int                       ADDRESS_WIDTH     = 8,
  parameter int                       BUS_WIDTH         = 32,
  parameter int                       REGISTERS         = 1,
  parameter bit                       PRE_DECODE        = 0,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS      = '0,
  parameter int                       BYTE_SIZE         = 256,
  parameter bit                       ERROR_STATUS      = 0,
  parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA = '0,
  parameter bit                       INSERT_SLICER     = 0,
  parameter bit                       RESPONSE_REGISTER = 0,
  parameter int                       TIMEOUT_CYCLES    = 0
)(
  input  logic           i_clk,
  input  logic           i_rst_n,
  rggen_bus_if.slave     bus_if,
  rggen_register_if.host register_if[REGISTERS]
);
  localparam logic [1:0] RGGEN_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
  localparam logic [1:0] DEFAULT_STATUS    = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
  localparam int         STROBE_WIDTH      = BUS_WIDTH / 8;
  localparam int         COUNT_WIDTH       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;

  state_e                   state;
  state_e                   state_next;
  logic                     issue;
  logic                     decode_hit;
  logic                     register_valid;
  logic                     timeout;
  logic                     complete;
  logic [1:0]               resp_status;
  logic [BUS_WIDTH-1:0]     resp_data;
  logic [1:0]               req_access;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [BUS_WIDTH-1:0]     req_write_data;
  logic [STROBE_WIDTH-1:0]  req_strobe;
  logic [REGISTERS-1:0]     reg_active;
  logic [REGISTERS-1:0]     reg_ready;
  logic [REGISTERS-1:0]     reg_hit;
  logic [1:0]               reg_status    [REGISTERS];
  logic [BUS_WIDTH-1:0]     reg_read_data [REGISTERS];

  if (INSERT_SLICER) begin : g_slicer
    logic [1:0]               access_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [BUS_WIDTH-1:0]     write_data_q;
    logic [STROBE_WIDTH-1:0]  strobe_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        access_q     <= '0;
        address_q    <= '0;
        write_data_q <= '0;
        strobe_q     <= '0;
      end else if (state == IDLE && bus_if.valid) begin
        access_q     <= bus_if.access;
        address_q    <= bus_if.address;
        write_data_q <= bus_if.write_data;
        strobe_q     <= bus_if.strobe;
      end
    end

    assign req_access     = access_q;
    assign req_address    = address_q;
    assign req_write_data = write_data_q;
    assign req_strobe     = strobe_q;
  end else begin : g_no_slicer
    assign req_access     = bus_if.access;
    assign req_address    = bus_if.address;
    assign req_write_data = bus_if.write_data;
    assign req_strobe     = bus_if.strobe;
  end

  // One extra address bit so BASE_ADDRESS + BYTE_SIZE may reach the top of the space.
  if (PRE_DECODE) begin : g_decode
    localparam logic [ADDRESS_WIDTH:0] END_ADDRESS =
      (ADDRESS_WIDTH + 1)'(BASE_ADDRESS) + (ADDRESS_WIDTH + 1)'(BYTE_SIZE);
    assign decode_hit = ({1'b0, req_address} >= {1'b0, BASE_ADDRESS}) &&
                        ({1'b0, req_address} < END_ADDRESS);
  end else begin : g_no_decode
    assign decode_hit = 1'b1;
  end

  assign issue          = ((state == IDLE) && bus_if.valid && !INSERT_SLICER) || (state == ISSUE);
  assign register_valid = issue && decode_hit;

  for (genvar i = 0; i < REGISTERS; i++) begin : g_channel
    assign register_if[i].valid      = register_valid;
    assign register_if[i].access     = req_access;
    assign register_if[i].address    = req_address;
    assign register_if[i].write_data = req_write_data;
    assign register_if[i].strobe     = req_strobe;
    assign reg_active[i]             = register_if[i].active;
    assign reg_ready[i]              = register_if[i].ready;
    assign reg_status[i]             = register_if[i].status;
    assign reg_read_data[i]          = register_if[i].read_data;
  end

  assign reg_hit = reg_ready & reg_active;

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    logic [COUNT_WIDTH-1:0] count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        count <= '0;
      end else if ((issue || state == WAIT) && !complete) begin
        count <= count + 1'b1;
      end else begin
        count <= '0;
      end
    end

    assign timeout = (state == WAIT) && (count == COUNT_WIDTH'(TIMEOUT_CYCLES));
  end else begin : g_no_timeout
    assign timeout = 1'b0;
  end

  always_comb begin
    complete    = 1'b0;
    resp_status = RGGEN_OKAY;
    resp_data   = '0;
    if (issue && !decode_hit) begin
      complete    = 1'b1;
      resp_status = RGGEN_SLAVE_ERROR;
      resp_data   = DEFAULT_READ_DATA;
    end else if (issue || state == WAIT) begin
      if (reg_active == '0) begin
        complete    = 1'b1;
        resp_status = DEFAULT_STATUS;
        resp_data   = DEFAULT_READ_DATA;
      end else if (reg_hit != '0) begin
        complete = 1'b1;
        for (int i = 0; i < REGISTERS; i++) begin
          if (reg_hit[i]) begin
            resp_status = resp_status | reg_status[i];
            resp_data   = resp_data | reg_read_data[i];
          end
        end
      end else if (timeout) begin
        complete    = 1'b1;
        resp_status = RGGEN_SLAVE_ERROR;
        resp_data   = DEFAULT_READ_DATA;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus_if.valid) begin
          if (INSERT_SLICER) state_next = ISSUE;
          else if (complete) state_next = RESPONSE_REGISTER ? RESPOND : IDLE;
          else               state_next = WAIT;
        end
      end
      ISSUE, WAIT: begin
        if (complete) state_next = RESPONSE_REGISTER ? RESPOND : IDLE;
        else          state_next = WAIT;
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  if (RESPONSE_REGISTER) begin : g_resp_reg
    logic                 ready_q;
    logic [1:0]           status_q;
    logic [BUS_WIDTH-1:0] read_data_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        ready_q     <= 1'b0;
        status_q    <= RGGEN_OKAY;
        read_data_q <= '0;
      end else begin
        ready_q <= complete;
        if (complete) begin
          status_q    <= resp_status;
          read_data_q <= resp_data;
        end
      end
    end

    assign bus_if.ready     = ready_q;
    assign bus_if.status    = status_q;
    assign bus_if.read_data = read_data_q;
  end else begin : g_resp_comb
    assign bus_if.ready     = complete;
    assign bus_if.status    = resp_status;
    assign bus_if.read_data = resp_data;
  end

`ifdef RGGEN_ENABLE_SVA
  ast_request_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bus_if.valid && !bus_if.ready) |=> (bus_if.valid && $stable(bus_if.access) &&
      $stable(bus_if.address) && $stable(bus_if.write_data) && $stable(bus_if.strobe)));
  ast_active_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(reg_active));
  ast_ready_in_active: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ((reg_ready & ~reg_active) == '0));
  ast_single_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    register_valid |=> !register_valid);
`endif
endmodule

// File: tb/tb_rggen_adapter_pipelined.sv
// Directed bench: five adapter configurations, table-driven single-cycle vectors
// plus hand-written multi-cycle sequences.
module tb_rggen_adapter_pipelined;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] EXO = 2'b01;
  localparam logic [1:0] SLV = 2'b10;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] WR  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  rggen_bus_if #(.ADDRESS_WIDTH(8),  .BUS_WIDTH(32)) bus0 ();
  rggen_bus_if #(.ADDRESS_WIDTH(8),  .BUS_WIDTH(32)) bus1 ();
  rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bus2 ();
  rggen_bus_if #(.ADDRESS_WIDTH(8),  .BUS_WIDTH(32)) bus3 ();
  rggen_bus_if #(.ADDRESS_WIDTH(8),  .BUS_WIDTH(32)) bus4 ();
  rggen_register_if #(.ADDRESS_WIDTH(8),  .BUS_WIDTH(32)) rif0 [4] ();
  rggen_register_if #(.ADDRESS_WIDTH(8),  .BUS_WIDTH(32)) rif1 [1] ();
  rggen_register_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) rif2 [1] ();
  rggen_register_if #(.ADDRESS_WIDTH(8),  .BUS_WIDTH(32)) rif3 [2] ();
  rggen_register_if #(.ADDRESS_WIDTH(8),  .BUS_WIDTH(32)) rif4 [1] ();

  rggen_adapter_pipelined #(.REGISTERS(4), .DEFAULT_READ_DATA(32'h0BAD_0BAD)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus_if(bus0), .register_if(rif0));
  rggen_adapter_pipelined #(.REGISTERS(1), .INSERT_SLICER(1), .RESPONSE_REGISTER(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus_if(bus1), .register_if(rif1));
  rggen_adapter_pipelined #(.ADDRESS_WIDTH(16), .REGISTERS(1), .PRE_DECODE(1),
    .BASE_ADDRESS(16'h0100), .BYTE_SIZE(32'h40), .DEFAULT_READ_DATA(32'hFFFF_FFFF)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus_if(bus2), .register_if(rif2));
  rggen_adapter_pipelined #(.REGISTERS(2), .ERROR_STATUS(1), .DEFAULT_READ_DATA(32'h5A5A_5A5A)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .bus_if(bus3), .register_if(rif3));
  rggen_adapter_pipelined #(.REGISTERS(1), .TIMEOUT_CYCLES(8), .DEFAULT_READ_DATA(32'hEEEE_EEEE)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus_if(bus4), .register_if(rif4));

  logic [3:0]  r0_active, r0_ready, r0_valid;
  logic [1:0]  r0_status;
  logic [31:0] r0_data [4];
  logic [1:0]  r3_active, r3_ready, r3_valid;
  logic [1:0]  r3_status;
  logic [31:0] r3_data [2];
  logic        r1_active, r1_ready, r1_valid;
  logic        r2_active, r2_ready, r2_valid;
  logic        r4_active, r4_ready, r4_valid;
  logic [31:0] r1_data, r2_data, r4_data;

  for (genvar g = 0; g < 4; g++) begin : g_r0
    assign rif0[g].active    = r0_active[g];
    assign rif0[g].ready     = r0_ready[g];
    assign rif0[g].status    = r0_status;
    assign rif0[g].read_data = r0_data[g];
    assign r0_valid[g]       = rif0[g].valid;
  end
  for (genvar g = 0; g < 2; g++) begin : g_r3
    assign rif3[g].active    = r3_active[g];
    assign rif3[g].ready     = r3_ready[g];
    assign rif3[g].status    = r3_status;
    assign rif3[g].read_data = r3_data[g];
    assign r3_valid[g]       = rif3[g].valid;
  end
  assign rif1[0].active = r1_active; assign rif1[0].ready = r1_ready;
  assign rif1[0].status = OK;        assign rif1[0].read_data = r1_data;
  assign r1_valid = rif1[0].valid;
  assign rif2[0].active = r2_active; assign rif2[0].ready = r2_ready;
  assign rif2[0].status = OK;        assign rif2[0].read_data = r2_data;
  assign r2_valid = rif2[0].valid;
  assign rif4[0].active = r4_active; assign rif4[0].ready = r4_ready;
  assign rif4[0].status = OK;        assign rif4[0].read_data = r4_data;
  assign r4_valid = rif4[0].valid;

  typedef struct {
    int          sel;
    logic [1:0]  access;
    logic [7:0]  address;
    logic [3:0]  active;
    logic [3:0]  ready;
    logic [1:0]  status;
    logic        exp_ready;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    logic        exp_rvalid;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic        a_ready;
    logic [1:0]  a_status;
    logic [31:0] a_data;
    logic [3:0]  a_rvalid, e_rvalid;
    @(negedge clk);
    if (v.sel == 0) begin
      bus0.valid = 1'b1; bus0.access = v.access; bus0.address = v.address;
      bus0.write_data = 32'hA5A5_0000 + 32'(idx); bus0.strobe = (v.access == WR) ? 4'hF : 4'h0;
      r0_active = v.active; r0_ready = v.ready; r0_status = v.status;
    end else begin
      bus3.valid = 1'b1; bus3.access = v.access; bus3.address = v.address;
      bus3.write_data = 32'h0; bus3.strobe = 4'h0;
      r3_active = v.active[1:0]; r3_ready = v.ready[1:0]; r3_status = v.status;
    end
    #1;
    if (v.sel == 0) begin
      a_ready = bus0.ready; a_status = bus0.status; a_data = bus0.read_data;
      a_rvalid = r0_valid; e_rvalid = {4{v.exp_rvalid}};
    end else begin
      a_ready = bus3.ready; a_status = bus3.status; a_data = bus3.read_data;
      a_rvalid = {2'b00, r3_valid}; e_rvalid = {2'b00, {2{v.exp_rvalid}}};
    end
    check($sformatf("vec%0d ready", idx),  64'(a_ready),  64'(v.exp_ready));
    check($sformatf("vec%0d status", idx), 64'(a_status), 64'(v.exp_status));
    check($sformatf("vec%0d data", idx),   64'(a_data),   64'(v.exp_data));
    check($sformatf("vec%0d rvalid", idx), 64'(a_rvalid), 64'(e_rvalid));
    @(posedge clk); #1;
    bus0.valid = 1'b0; bus3.valid = 1'b0;
    r0_active = '0; r0_ready = '0; r3_active = '0; r3_ready = '0;
  endtask

  task automatic run_decode(input logic [15:0] addr, input logic act, input logic [1:0] e_status,
                            input logic [31:0] e_data, input logic e_rvalid);
    @(negedge clk);
    bus2.valid = 1'b1; bus2.access = RD; bus2.address = addr;
    r2_active = act; r2_ready = act;
    #1;
    check($sformatf("decode %h ready", addr),  64'(bus2.ready),     64'(1'b1));
    check($sformatf("decode %h status", addr), 64'(bus2.status),    64'(e_status));
    check($sformatf("decode %h data", addr),   64'(bus2.read_data), 64'(e_data));
    check($sformatf("decode %h rvalid", addr), 64'(r2_valid),       64'(e_rvalid));
    @(posedge clk); #1;
    bus2.valid = 1'b0; r2_active = 1'b0; r2_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus0.valid = 0; bus0.access = RD; bus0.address = '0; bus0.write_data = '0; bus0.strobe = '0;
    bus1.valid = 0; bus1.access = RD; bus1.address = '0; bus1.write_data = '0; bus1.strobe = '0;
    bus2.valid = 0; bus2.access = RD; bus2.address = '0; bus2.write_data = '0; bus2.strobe = '0;
    bus3.valid = 0; bus3.access = RD; bus3.address = '0; bus3.write_data = '0; bus3.strobe = '0;
    bus4.valid = 0; bus4.access = RD; bus4.address = '0; bus4.write_data = '0; bus4.strobe = '0;
    r0_active = '0; r0_ready = '0; r0_status = OK;
    r0_data[0] = 32'h1111_0000; r0_data[1] = 32'hDEAD_BEEF;
    r0_data[2] = 32'h2222_2222; r0_data[3] = 32'h3333_3333;
    r3_active = '0; r3_ready = '0; r3_status = OK;
    r3_data[0] = 32'hA0A0_0001; r3_data[1] = 32'hB0B0_0002;
    r1_active = 0; r1_ready = 0; r1_data = 32'h0000_0077;
    r2_active = 0; r2_ready = 0; r2_data = 32'h13C1_3C00;
    r4_active = 0; r4_ready = 0; r4_data = 32'h0000_0099;

    vecs[0] = '{0, RD, 8'h04, 4'b0010, 4'b0010, OK,  1'b1, OK,  32'hDEAD_BEEF, 1'b1};
    vecs[1] = '{0, RD, 8'h08, 4'b0100, 4'b0100, SLV, 1'b1, SLV, 32'h2222_2222, 1'b1};
    vecs[2] = '{0, WR, 8'h0C, 4'b1000, 4'b1000, OK,  1'b1, OK,  32'h3333_3333, 1'b1};
    vecs[3] = '{0, RD, 8'h10, 4'b0000, 4'b0000, OK,  1'b1, OK,  32'h0BAD_0BAD, 1'b1};
    vecs[4] = '{1, RD, 8'h20, 4'b0000, 4'b0000, OK,  1'b1, SLV, 32'h5A5A_5A5A, 1'b1};
    vecs[5] = '{1, RD, 8'h04, 4'b0010, 4'b0010, OK,  1'b1, OK,  32'hB0B0_0002, 1'b1};
    vecs[6] = '{1, RD, 8'h00, 4'b0001, 4'b0001, EXO, 1'b1, EXO, 32'hA0A0_0001, 1'b1};

    // reset state, including the registered response path of u1
    repeat (2) @(negedge clk);
    check("reset u0 ready", 64'(bus0.ready), 64'(1'b0));
    check("reset u0 data",  64'(bus0.read_data), 64'(32'h0));
    check("reset u1 ready", 64'(bus1.ready), 64'(1'b0));
    check("reset u1 status", 64'(bus1.status), 64'(OK));
    check("reset u1 data",  64'(bus1.read_data), 64'(32'h0));
    check("reset u2 rvalid", 64'(r2_valid), 64'(1'b0));
    check("reset u4 ready", 64'(bus4.ready), 64'(1'b0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle u0 rvalid", 64'(r0_valid), 64'(4'h0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // u0 with register latency 2 and all options off
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus0.valid = 1; bus0.access = RD; bus0.address = 8'h00; r0_active = 4'b0001; r0_ready = 4'b0000;
      end
      if (k == 2) r0_ready = 4'b0001;
      if (k == 3) begin bus0.valid = 0; r0_active = '0; r0_ready = '0; end
      #1;
      if (k < 3) begin
        check($sformatf("lat2 k%0d ready", k), 64'(bus0.ready), 64'(k == 2));
        check($sformatf("lat2 k%0d rvalid", k), 64'(r0_valid), (k == 0) ? 64'h0F : 64'h0);
        if (k == 2) check("lat2 data", 64'(bus0.read_data), 64'(32'h1111_0000));
      end
    end

    // u1 slicer + registered response, write with latency 2
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus1.valid = 1; bus1.access = WR; bus1.address = 8'h10;
        bus1.write_data = 32'h1234_5678; bus1.strobe = 4'hF; r1_active = 1;
      end
      r1_ready = (k == 3);
      if (k == 5) begin bus1.valid = 0; r1_active = 0; end
      #1;
      check($sformatf("slice k%0d ready", k), 64'(bus1.ready), 64'(k == 4));
      check($sformatf("slice k%0d rvalid", k), 64'(r1_valid), 64'(k == 1));
      if (k == 1) begin
        check("slice access", 64'(rif1[0].access), 64'(WR));
        check("slice address", 64'(rif1[0].address), 64'(8'h10));
        check("slice wdata", 64'(rif1[0].write_data), 64'(32'h1234_5678));
        check("slice strobe", 64'(rif1[0].strobe), 64'(4'hF));
      end
      if (k == 4) begin
        check("slice status", 64'(bus1.status), 64'(OK));
        check("slice data", 64'(bus1.read_data), 64'(32'h0000_0077));
      end
    end

    // u2 pre-decode window 0x100..0x13F
    run_decode(16'h0140, 1'b0, SLV, 32'hFFFF_FFFF, 1'b0);
    run_decode(16'h013C, 1'b1, OK,  32'h13C1_3C00, 1'b1);
    run_decode(16'h00FF, 1'b0, SLV, 32'hFFFF_FFFF, 1'b0);
    run_decode(16'h0100, 1'b1, OK,  32'h13C1_3C00, 1'b1);

    // u4 timeout at cycle 8, late ready at 10 ignored, then a normal access
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus4.valid = 1; bus4.access = RD; bus4.address = 8'h20; r4_active = 1; r4_ready = 0;
      end
      if (k == 9)  bus4.valid = 0;
      if (k == 10) r4_ready = 1;
      if (k == 11) r4_ready = 0;
      if (k == 12) begin bus4.valid = 1; r4_ready = 1; end
      #1;
      check($sformatf("tmo k%0d ready", k), 64'(bus4.ready), 64'(k == 8 || k == 12));
      check($sformatf("tmo k%0d rvalid", k), 64'(r4_valid), 64'(k == 0 || k == 12));
      if (k == 8) begin
        check("tmo status", 64'(bus4.status), 64'(SLV));
        check("tmo data", 64'(bus4.read_data), 64'(32'hEEEE_EEEE));
      end
      if (k == 12) begin
        check("tmo next status", 64'(bus4.status), 64'(OK));
        check("tmo next data", 64'(bus4.read_data), 64'(32'h0000_0099));
      end
    end
    @(posedge clk); #1;
    bus4.valid = 0; r4_active = 0; r4_ready = 0;

    // reset in WAIT on u4 (register latency 5), stale ready must not escape
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus4.valid = 1; bus4.address = 8'h24; r4_active = 1; r4_ready = 0; r4_data = 32'h0000_00AB;
      end
      if (k == 2) begin rst_n = 0; bus4.valid = 0; end
      if (k == 4) rst_n = 1;
      if (k == 5) r4_ready = 1;
      if (k == 6) r4_ready = 0;
      if (k == 8) begin bus4.valid = 1; r4_ready = 1; end
      #1;
      if (k == 2) begin
        check("rst wait status", 64'(bus4.status), 64'(OK));
        check("rst wait data", 64'(bus4.read_data), 64'(32'h0));
        check("rst wait rvalid", 64'(r4_valid), 64'(1'b0));
      end
      if (k >= 1) check($sformatf("rst k%0d ready", k), 64'(bus4.ready), 64'(k == 8));
      if (k == 8) begin
        check("rst next data", 64'(bus4.read_data), 64'(32'h0000_00AB));
        check("rst next rvalid", 64'(r4_valid), 64'(1'b1));
      end
    end
    @(posedge clk); #1;
    bus4.valid = 0; r4_active = 0; r4_ready = 0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rggen_adapter_pipelined.md
# rggen_adapter_pipelined

Parametrised bus-to-register adapter between a protocol bridge (APB/AXI4-Lite/Avalon/Wishbone front end driving `rggen_bus_if`) and the register array (`rggen_register_if`). It adds an optional request slice, an optional registered response, pre-decode range checking and a response timeout. With every option disabled it is cycle-equivalent to the existing common adapter. A one-hot response mux returns `ready`, `status` and `read_data` to the bus.

## Interface
- ADDRESS_WIDTH, 8: bus address width.
- BUS_WIDTH, 32: data width; strobe width is BUS_WIDTH/8.
- REGISTERS, 1: number of `register_if` channels, ≥1.
- PRE_DECODE, 0: 1 = range-check the address against BASE_ADDRESS/BYTE_SIZE before forwarding.
- BASE_ADDRESS, '0: first byte address of this block.
- BYTE_SIZE, 256: byte span of this block.
- ERROR_STATUS, 0: 1 = no-hit response is RGGEN_SLAVE_ERROR, else RGGEN_OKAY.
- DEFAULT_READ_DATA, '0: read data returned on no-hit, decode error or timeout.
- INSERT_SLICER, 0: 1 = register the request before presenting it to `register_if`.
- RESPONSE_REGISTER, 0: 1 = register `ready`/`status`/`read_data` before returning them to `bus_if`.
- TIMEOUT_CYCLES, 0: 0 = no timeout; N>0 = abort after N wait cycles.
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- bus_if  rggen_bus_if.slave  interface  bus-side request/response.
- register_if  rggen_register_if.host  array[REGISTERS]  register-side request/response.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE, `bus_if.valid`=1:
  - INSERT_SLICER=0: issue in the same cycle; go to WAIT, or stay IDLE if the response is already complete.
  - INSERT_SLICER=1: capture access/address/write_data/strobe; go to ISSUE.
- ISSUE: pulse the request for one cycle; go to WAIT.
- Request forwarding:
  - `register_if[i].valid` is a single-cycle pulse per transaction, broadcast to all channels.
  - access/address/write_data/strobe come from the bus (slicer off) or the captured copy (slicer on).
- Pre-decode (PRE_DECODE=1): address < BASE_ADDRESS or ≥ BASE_ADDRESS+BYTE_SIZE gives a decode error.
  - No `register_if` valid is issued.
  - Response is RGGEN_SLAVE_ERROR with DEFAULT_READ_DATA in the issue cycle.
- Response selection:
  - Channel `i` with `ready[i]`=1 supplies status/read_data via one-hot mux.
  - If no channel is `active`, respond immediately with DEFAULT_STATUS/DEFAULT_READ_DATA.
- Timeout:
  - In WAIT, counter (width $clog2(TIMEOUT_CYCLES+1)) increments each cycle without ready.
  - Reaching TIMEOUT_CYCLES forces RGGEN_SLAVE_ERROR with DEFAULT_READ_DATA.
  - Any late `ready` from that transaction is ignored until the next IDLE issue.
- Response path:
  - RESPONSE_REGISTER=0: response returns combinationally; FSM returns to IDLE on completion.
  - RESPONSE_REGISTER=1: completion loads a response register; go to RESPOND; `bus_if.ready` is asserted for exactly one cycle; then IDLE.
- Reset values: state IDLE; counter 0; `bus_if.ready` 0; `bus_if.status` RGGEN_OKAY; `bus_if.read_data` '0; all `register_if[i].valid` 0; slice registers '0.
- Reset asserted mid-transaction: outstanding transaction dropped; no response issued.
- SVA (RGGEN_ENABLE_SVA):
  - Request held stable until ready.
  - `active` is one-hot or zero.
  - `ready` ⊆ `active`.
  - At most one `register_if.valid` pulse per transaction.

## Timing
- Latency from `bus_if.valid` to `bus_if.ready` = INSERT_SLICER + L + RESPONSE_REGISTER cycles, where L is register latency (0 = ready in the issue cycle).
- All options off, L=0: ready in the same cycle as valid.
- Decode error or no-hit latency = INSERT_SLICER + RESPONSE_REGISTER.
- Timeout: ready at cycle INSERT_SLICER + TIMEOUT_CYCLES + RESPONSE_REGISTER.
- Back-to-back: with RESPONSE_REGISTER=0 and INSERT_SLICER=0, a new valid is accepted the cycle after ready. Otherwise the next issue occurs ≥1 cycle after returning to IDLE.
- Bus master holds valid and request fields until ready; the adapter never re-issues while not IDLE.

## Test plan
- All options off, REGISTERS=4, read addr 0x04 hitting reg1 with L=0, read_data 0xDEADBEEF -> same-cycle `bus_if.ready`, status OKAY, data 0xDEADBEEF; exactly one valid pulse.
- INSERT_SLICER=1, RESPONSE_REGISTER=1, write 0x12345678 strobe 0xF, L=2 -> `bus_if.ready` 4 cycles after valid, one cycle wide, status OKAY.
- PRE_DECODE=1, BASE_ADDRESS=0x100, BYTE_SIZE=0x40, read 0x140 -> no `register_if.valid`; SLAVE_ERROR with DEFAULT_READ_DATA (0xFFFFFFFF) in the same cycle; read 0x13C -> forwarded.
- No-hit read, ERROR_STATUS=1 vs 0 -> same-cycle ready with SLAVE_ERROR vs OKAY, data DEFAULT_READ_DATA.
- TIMEOUT_CYCLES=8, active register never readies -> SLAVE_ERROR at cycle 8; late ready at cycle 10 ignored; next transaction completes normally.
- i_rst_n asserted in WAIT with L=5 -> outputs return to reset values immediately; no ready after deassertion; next request served normally.
